// File: rtl/gray_pkg.sv
// Shared definitions for the Gray code generator: default width and the
// bin-to-Gray / width-to-mask helpers used by the counter and the encoder.
package gray_pkg;

  // Default code width of the generator
  localparam int unsigned GRAY_DEFAULT_WIDTH = 16;

  // Widest code selectable through the 4-bit num_bits port (0 means 16)
  localparam int unsigned GRAY_NB_MAX = 16;

  // Working width of the helper functions; instances zero-extend into it
  localparam int unsigned GRAY_FN_W = 64;

  typedef logic [GRAY_FN_W-1:0]   gray_word_t;
  typedef logic [GRAY_NB_MAX-1:0] gray_mask_t;

  // Reflected binary Gray code of a binary word
  function automatic gray_word_t bin_to_gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Mask with the low nb bits set; nb = 0 selects the full 16 bits
  function automatic gray_mask_t width_to_mask(input logic [3:0] nb);
    gray_mask_t m;
    if (nb == 4'd0) begin
      m = '1;
    end else begin
      m = (gray_mask_t'(1) << nb) - gray_mask_t'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/gray_code_generator_encoder.sv
// Combinational encoder: binary count and active-width mask in, masked
// Gray word out. Supports WIDTH up to the package working width (64).
module gray_encoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] gray
);

  gray_word_t gray_full;

  // Convert to Gray at the working width, then trim and mask to the active bits
  always_comb begin
    gray_full = bin_to_gray(GRAY_FN_W'(bin));
    gray      = gray_full[WIDTH-1:0] & mask;
  end

endmodule

// File: rtl/gray_code_generator.sv
// Gray code generator: a masked binary counter whose next value is encoded
// to Gray and registered together with the count, so gray_out carries no
// combinational path from any input. A change of num_bits restarts the
// sequence at 0; stepping from the last code back to 0 raises wrap for one
// cycle.
module gray_code_generator
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [3:0]       num_bits,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] mask;
  logic [3:0]       nb_q;
  logic             nb_changed;
  logic             at_last;
  logic             wrap_next;
  gray_mask_t       mask16;
  gray_word_t       mask_full;

  // Active-width mask; for WIDTH < 16 the upper mask bits simply fall away,
  // which yields the effective width min(N, WIDTH)
  always_comb begin
    mask16    = width_to_mask(num_bits);
    mask_full = GRAY_FN_W'(mask16);
    mask      = mask_full[WIDTH-1:0];
  end

  // Next count and wrap: width change restarts, enable steps, otherwise hold
  always_comb begin
    nb_changed = (num_bits != nb_q);
    at_last    = (bin_q == mask);
    bin_next   = bin_q;
    wrap_next  = 1'b0;
    if (nb_changed) begin
      bin_next = '0;
    end else if (enable) begin
      bin_next  = (bin_q + WIDTH'(1)) & mask;
      wrap_next = at_last;
    end
  end

  // Encoding the next count lets bin and gray_out update on the same edge
  gray_encoder #(
    .WIDTH (WIDTH)
  ) u_encoder (
    .bin  (bin_next),
    .mask (mask),
    .gray (gray_next)
  );

  // State registers; reset clears the sequence and captures the current width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
      nb_q     <= num_bits;
    end else begin
      bin_q    <= bin_next;
      gray_out <= gray_next;
      wrap     <= wrap_next;
      nb_q     <= num_bits;
    end
  end

endmodule

// File: tb/tb_gray_code_generator.sv
// Self-checking bench for gray_code_generator (WIDTH = 16): directed
// scenarios followed by randomized enable / width / reset traffic, checked
// against a sequence-index reference model.
module tb_gray_code_generator;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  num_bits;
  logic [15:0] gray_out;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: position in the sequence, active width, sampled width
  int          m_cnt;
  logic        m_wrap;
  logic [3:0]  m_nbq;
  logic [15:0] prev_gray;

  gray_code_generator #(
    .WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .num_bits (num_bits),
    .gray_out (gray_out),
    .wrap     (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int eff_n(input logic [3:0] nb);
    return (nb == 4'd0) ? 16 : int'(nb);
  endfunction

  function automatic logic [15:0] exp_gray();
    int g;
    g = m_cnt ^ (m_cnt >> 1);
    return g[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_wrap = 1'b0;
    m_nbq  = num_bits;
  endtask

  task automatic model_edge();
    if (num_bits != m_nbq) begin
      m_cnt  = 0;
      m_wrap = 1'b0;
    end else if (enable) begin
      if (m_cnt == (1 << eff_n(num_bits)) - 1) begin
        m_cnt  = 0;
        m_wrap = 1'b1;
      end else begin
        m_cnt  = m_cnt + 1;
        m_wrap = 1'b0;
      end
    end else begin
      m_wrap = 1'b0;
    end
    m_nbq = num_bits;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_gray"}, 32'(gray_out), 32'(exp_gray()));
    check({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  // One clock edge with the given inputs; outputs sampled 1 time unit later
  task automatic tick(input logic en, input logic [3:0] nb);
    enable   = en;
    num_bits = nb;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset pulse placed between clock edges
  task automatic async_reset_pulse(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check({tag, "_rst_gray"}, 32'(gray_out), 32'h0);
    check({tag, "_rst_wrap"}, 32'(wrap), 32'h0);
    #1 rst = 1'b0;
  endtask

  logic [15:0] seq4 [16];
  logic [15:0] seq3 [8];

  initial begin
    seq4 = '{16'h1, 16'h3, 16'h2, 16'h6, 16'h7, 16'h5, 16'h4, 16'hC,
             16'hD, 16'hF, 16'hE, 16'hA, 16'hB, 16'h9, 16'h8, 16'h0};
    seq3 = '{16'h1, 16'h3, 16'h2, 16'h6, 16'h7, 16'h5, 16'h4, 16'h0};

    // Reset with enable low, then release and idle
    rst      = 1'b1;
    enable   = 1'b0;
    num_bits = 4'd4;
    #1;
    model_reset();
    check("reset_gray", 32'(gray_out), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_clk_gray", 32'(gray_out), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 4'd4);
      check("idle_gray", 32'(gray_out), 32'h0);
      check("idle_wrap", 32'(wrap), 32'h0);
    end

    // Full 4-bit sequence with wrap on the 0x8 -> 0x0 step
    prev_gray = gray_out;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 4'd4);
      check("seq4", 32'(gray_out), 32'(seq4[i]));
      check("seq4_wrap", 32'(wrap), (i == 15) ? 32'h1 : 32'h0);
      check("seq4_onebit", 32'($countones(prev_gray ^ gray_out)), 32'h1);
      check_model("seq4_model");
      prev_gray = gray_out;
    end
    tick(1'b0, 4'd4);
    check("wrap_single_cycle", 32'(wrap), 32'h0);

    // Count to 0xD then hold for three disabled edges
    for (int i = 0; i < 9; i++) tick(1'b1, 4'd4);
    check("reach_d", 32'(gray_out), 32'hD);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'd4);
      check("hold_d", 32'(gray_out), 32'hD);
      check("hold_wrap", 32'(wrap), 32'h0);
    end

    // Width change 4 -> 3 restarts at 0 without wrap, then 3-bit sequence
    tick(1'b1, 4'd3);
    check("nb_change_gray", 32'(gray_out), 32'h0);
    check("nb_change_wrap", 32'(wrap), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 4'd3);
      check("seq3", 32'(gray_out), 32'(seq3[i]));
      check("seq3_wrap", 32'(wrap), (i == 7) ? 32'h1 : 32'h0);
    end

    // Full 16-bit width: count to 0xFFFF then wrap
    tick(1'b1, 4'd0);
    check("nb0_restart", 32'(gray_out), 32'h0);
    for (int i = 0; i < 65535; i++) tick(1'b1, 4'd0);
    check("full_last", 32'(gray_out), 32'h8000);
    check("full_last_wrap", 32'(wrap), 32'h0);
    tick(1'b1, 4'd0);
    check("full_wrap_gray", 32'(gray_out), 32'h0);
    check("full_wrap", 32'(wrap), 32'h1);

    // Asynchronous reset mid-sequence at 0x6
    tick(1'b1, 4'd4);
    for (int i = 0; i < 4; i++) tick(1'b1, 4'd4);
    check("pre_rst_6", 32'(gray_out), 32'h6);
    async_reset_pulse("mid");
    tick(1'b1, 4'd4);
    check("post_rst_first", 32'(gray_out), 32'h1);
    check_model("post_rst_model");

    // Randomized traffic against the model
    prev_gray = gray_out;
    for (int i = 0; i < 600; i++) begin
      logic       en;
      logic [3:0] nb;
      logic       step;
      en = ($urandom_range(0, 3) != 0);
      nb = num_bits;
      if ($urandom_range(0, 15) == 0) nb = 4'($urandom_range(0, 4));
      step = en && (nb == m_nbq);
      tick(en, nb);
      check_model("rand");
      if (step) check("rand_onebit", 32'($countones(prev_gray ^ gray_out)), 32'h1);
      else if (!en && nb == num_bits && m_cnt != 0) check("rand_hold", 32'(gray_out), 32'(prev_gray));
      prev_gray = gray_out;
      if ($urandom_range(0, 49) == 0) begin
        async_reset_pulse("rand");
        prev_gray = gray_out;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_code_generator.md
GRAY_CODE_GENERATOR -- requirements
Module: gray_code_generator

Interface
REQ-001 Parameter: WIDTH, default 16, maximum code width in bits and width of gray_out.
REQ-002 Port: clk  input  1  single clock for all state; rising-edge triggered.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: enable  input  1  advance request; when high at a clock edge the sequence steps once.
REQ-005 Port: num_bits  input  4  active code width N; 1..15 selects N bits, 0 selects the full 16 bits.
REQ-006 Port: gray_out  output  WIDTH  current Gray code word; bits at position N and above are always 0.
REQ-007 Port: wrap  output  1  single-cycle pulse, high in the cycle after the sequence returns from its last code to 0.

Function
REQ-008 The block SHALL hold an internal WIDTH-bit binary counter `bin` and SHALL drive gray_out = (bin XOR (bin >> 1)) AND mask, where mask has its low N bits set.
REQ-009 The block SHALL register gray_out, so gray_out changes only on a rising clk edge or on rst assertion.
REQ-010 The block SHALL update bin and gray_out on the same edge, giving zero extra latency between count and code.
REQ-011 On an edge with enable=1 and unchanged num_bits, the block SHALL set bin <= (bin + 1) AND mask.
REQ-012 When bin = 2^N - 1 on such an edge, the next bin SHALL be 0, gray_out SHALL become 0, and wrap SHALL be 1 for exactly one cycle.
REQ-013 On an edge with enable=0, the block SHALL hold bin and gray_out, and wrap SHALL be 0.
REQ-014 The block SHALL register num_bits each cycle; when the sampled num_bits differs from the registered value, bin and gray_out SHALL restart at 0 on that edge, regardless of enable.
REQ-015 A num_bits change SHALL NOT assert wrap.
REQ-016 Consecutive gray_out values SHALL differ in exactly one bit, including the wrap step 2^N-1 -> 0.
REQ-017 The num_bits values 0 and 16-equivalent SHALL be treated identically, as the full-width 16-bit sequence.
REQ-018 For WIDTH < 16, the effective N SHALL be min(N, WIDTH).
REQ-019 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-020 While rst=1, bin, gray_out and wrap SHALL be 0, and the registered num_bits SHALL load the current num_bits.
REQ-021 Reset asserted mid-sequence SHALL take effect immediately, without waiting for clk.
REQ-022 After rst deasserts, the first enabled edge SHALL produce gray_out = 1.
REQ-023 Reset SHALL take priority over enable and over a num_bits change.

Structure
REQ-024 A shared package gray_pkg SHALL hold the WIDTH default (16), a bin-to-Gray function, and a width-to-mask function (0 -> all ones).
REQ-025 The block SHALL use one natural combinational sub-module, gray_encoder (bin, mask -> masked Gray word), instantiated once.
REQ-026 The counter, num_bits change detect and wrap logic SHALL reside in gray_code_generator.

Verification
REQ-027 Scenario: rst=1, num_bits=4, enable=0, then rst=0 -> gray_out stays 0x0 and wrap stays 0.
REQ-028 Scenario: num_bits=4, enable=1 for 16 edges -> gray_out follows 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0, with wrap pulsing after the 0x8 -> 0x0 step.
REQ-029 Scenario: num_bits=4 at gray_out=0xD, then enable=0 for 3 edges -> gray_out holds 0xD.
REQ-030 Scenario: num_bits changed from 4 to 3 mid-count -> gray_out=0 on that edge, then 1,3,2,6,7,5,4,0 with wrap after the 4 -> 0 step.
REQ-031 Scenario: num_bits=0, bin preloaded by counting to 0xFFFF, then one enabled edge -> gray_out goes 0x8000 -> 0x0000 and wrap=1.
REQ-032 Scenario: rst pulsed asynchronously between edges at gray_out=0x6 -> gray_out=0 immediately, and 0x1 on the first enabled edge after release.
